// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2x2 stride-2 max/average pooling over a raster-ordered frame,
// keeping one partial (max or pair sum) per window column in a half-row line buffer.
module pool2d_stream #(
  parameter int DATA_W = 16,
  parameter int ROW_LEN = 8,
  parameter int NUM_ROWS = 8,
  parameter int MODE = 0,
  parameter int SIGNED = 0,
  localparam int NWIN = (ROW_LEN / 2) * (NUM_ROWS / 2),
  localparam int AW = NWIN > 1 ? $clog2(NWIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic [AW-1:0]     addr,
  output logic              done
);
  localparam int CW = $clog2(ROW_LEN);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int KW = ROW_LEN > 2 ? $clog2(ROW_LEN / 2) : 1;
  localparam int PW = DATA_W + 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d, result_q, result_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  logic [AW-1:0] addr_q, addr_d, win_q, win_d;
  logic [PW-1:0] lb_q [ROW_LEN/2];
  logic [PW-1:0] a_x, b_x, pair, part;
  logic [PW:0] p_x, q_x, sum4, avg;
  logic [KW-1:0] k;
  logic odd_col, odd_row, last_col, fin;

  function automatic logic gt(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return SIGNED != 0 ? $signed(a) > $signed(b) : a > b;
  endfunction

  always_comb begin
    a_x = SIGNED != 0 ? {hold_q[DATA_W-1], hold_q} : {1'b0, hold_q};
    b_x = SIGNED != 0 ? {in[DATA_W-1], in} : {1'b0, in};
    pair = MODE != 0 ? a_x + b_x : (gt(a_x, b_x) ? a_x : b_x);
    k = KW'(col_q >> 1);
    part = lb_q[k];
    p_x = SIGNED != 0 ? {part[PW-1], part} : {1'b0, part};
    q_x = SIGNED != 0 ? {pair[PW-1], pair} : {1'b0, pair};
    sum4 = p_x + q_x;
    avg = SIGNED != 0 ? $signed(sum4) >>> 2 : sum4 >> 2;
    odd_col = col_q[0];
    odd_row = row_q[0];
    last_col = col_q == CW'(ROW_LEN - 1);
    fin = load && odd_col && odd_row;
    col_d = load ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = (load && last_col) ? (row_q == RW'(NUM_ROWS - 1) ? '0 : row_q + 1'b1) : row_q;
    hold_d = (load && !odd_col) ? in : hold_q;
    out_valid_d = fin;
    done_d = fin && win_q == AW'(NWIN - 1);
    addr_d = fin ? win_q : addr_q;
    win_d = fin ? (done_d ? '0 : win_q + 1'b1) : win_q;
    result_d = fin ? (MODE != 0 ? DATA_W'(avg) : DATA_W'(gt(part, pair) ? part : pair)) : result_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      hold_q <= '0;
      result_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      win_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hold_q <= hold_d;
      result_q <= result_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
      addr_q <= addr_d;
      win_q <= win_d;
    end

  // Even-row entries are always written before the odd row reads them, so no reset.
  always_ff @(posedge clk)
    if (load && odd_col && !odd_row) lb_q[k] <= pair;

  assign result = result_q;
  assign out_valid = out_valid_q;
  assign addr = addr_q;
  assign done = done_q;
endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: five pooling variants driven by one shared random stream and checked
// against a per-window arithmetic model of max / floor-average.
module tb_pool2d_stream;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] r0, r1, r2, r3;
  logic [7:0] r4;
  logic [3:0] a0, a1, a2, a3, a4;
  logic [4:0] ovv, dnv;
  localparam int DW[5] = '{16, 16, 16, 16, 8};
  localparam int MD[5] = '{0, 1, 0, 1, 1};
  localparam int SG[5] = '{0, 0, 1, 1, 0};
  int total = 0, bad = 0, br = 0, bc = 0, pulses = 0, laddr = 0;
  logic [15:0] img [8][8];
  logic [15:0] lres [5];

  always #5 clk = ~clk;

  pool2d_stream #(.DATA_W(16), .MODE(0), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .load(load), .in(din),
    .result(r0), .out_valid(ovv[0]), .addr(a0), .done(dnv[0]));
  pool2d_stream #(.DATA_W(16), .MODE(1), .SIGNED(0)) u1 (.clk(clk), .rst(rst), .load(load), .in(din),
    .result(r1), .out_valid(ovv[1]), .addr(a1), .done(dnv[1]));
  pool2d_stream #(.DATA_W(16), .MODE(0), .SIGNED(1)) u2 (.clk(clk), .rst(rst), .load(load), .in(din),
    .result(r2), .out_valid(ovv[2]), .addr(a2), .done(dnv[2]));
  pool2d_stream #(.DATA_W(16), .MODE(1), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .load(load), .in(din),
    .result(r3), .out_valid(ovv[3]), .addr(a3), .done(dnv[3]));
  pool2d_stream #(.DATA_W(8), .MODE(1), .SIGNED(0)) u4 (.clk(clk), .rst(rst), .load(load), .in(din[7:0]),
    .result(r4), .out_valid(ovv[4]), .addr(a4), .done(dnv[4]));

  function automatic logic [15:0] rd(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return {8'h00, r4};
    endcase
  endfunction

  function automatic logic [3:0] ra(input int i);
    case (i)
      0: return a0;
      1: return a1;
      2: return a2;
      3: return a3;
      default: return a4;
    endcase
  endfunction

  // Interpret the four raw window samples per variant, then max or floor(sum/4).
  function automatic logic [15:0] exp_res(input int i, input logic [15:0] p0, input logic [15:0] p1,
                                          input logic [15:0] p2, input logic [15:0] p3);
    logic [15:0] raw [4];
    int v [4];
    int m, s, q, mask;
    raw = '{p0, p1, p2, p3};
    mask = (1 << DW[i]) - 1;
    for (int j = 0; j < 4; j++) begin
      v[j] = int'(raw[j]) & mask;
      if (SG[i] != 0 && v[j] >= (1 << (DW[i] - 1))) v[j] -= (1 << DW[i]);
    end
    m = v[0];
    s = 0;
    for (int j = 0; j < 4; j++) begin
      if (v[j] > m) m = v[j];
      s += v[j];
    end
    q = s / 4;
    if (s < 0 && s % 4 != 0) q -= 1;
    return 16'((MD[i] == 0 ? m : q) & mask);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0h want=%0h", tag, i, o, e);
    end
  endtask

  task automatic idle_check();
    for (int i = 0; i < 5; i++) begin
      chk("ov_idle", i, 32'(ovv[i]), 0);
      chk("done_idle", i, 32'(dnv[i]), 0);
      chk("res_hold", i, 32'(rd(i)), 32'(lres[i]));
      chk("addr_hold", i, 32'(ra(i)), laddr);
    end
  endtask

  task automatic send(input logic [15:0] v, input int gap);
    repeat (gap) begin
      load = 1'b0;
      @(posedge clk);
      #1;
      idle_check();
    end
    load = 1'b1;
    din = v;
    img[br][bc] = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (br % 2 == 1 && bc % 2 == 1) begin
      laddr = (br / 2) * 4 + bc / 2;
      if (ovv[0]) pulses++;
      for (int i = 0; i < 5; i++) begin
        lres[i] = exp_res(i, img[br-1][bc-1], img[br-1][bc], img[br][bc-1], img[br][bc]);
        chk("ov", i, 32'(ovv[i]), 1);
        chk("done", i, 32'(dnv[i]), 32'(laddr == 15));
        chk("res", i, 32'(rd(i)), 32'(lres[i]));
        chk("addr", i, 32'(ra(i)), laddr);
      end
    end else idle_check();
    bc = (bc + 1) % 8;
    if (bc == 0) br = (br + 1) % 8;
  endtask

  task automatic send_rand(input int n, input int gmax);
    for (int j = 0; j < n; j++) send(16'($urandom), int'($urandom_range(gmax, 0)));
  endtask

  task automatic zero_check(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_res"}, i, 32'(rd(i)), 0);
      chk({tag, "_ov"}, i, 32'(ovv[i]), 0);
      chk({tag, "_done"}, i, 32'(dnv[i]), 0);
      chk({tag, "_addr"}, i, 32'(ra(i)), 0);
    end
  endtask

  task automatic model_reset();
    br = 0;
    bc = 0;
    laddr = 0;
    for (int i = 0; i < 5; i++) lres[i] = '0;
  endtask

  initial begin
    model_reset();
    #1;
    zero_check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    send(38, 0); send(34, 0); send(25, 0); send(27, 0);
    send_rand(4, 0);
    send(45, 0); send(12, 1);
    chk("max_w0", 0, 32'(r0), 45);
    chk("avg_w0", 1, 32'(r1), 32);
    send(10, 0); send(6, 2);
    chk("max_w1", 0, 32'(r0), 27);
    chk("avg_w1", 1, 32'(r1), 17);
    chk("addr_w1", 0, 32'(a0), 1);
    send_rand(52, 2);
    chk("pulses_a", 0, pulses, 16);
    pulses = 0;
    send(16'hFFFB, 0); send(16'hFFFD, 0);
    send_rand(6, 1);
    send(16'hFFF8, 0); send(16'hFFFF, 3);
    chk("smax", 2, 32'(r2), 32'hFFFF);
    chk("savg", 3, 32'(r3), 32'hFFFB);
    chk("restart_addr", 0, 32'(a0), 0);
    send_rand(54, 2);
    chk("pulses_b", 0, pulses, 16);
    send_rand(64, 3);
    send_rand(13, 1);
    #2;
    rst = 1'b1;
    #1;
    zero_check("midrst");
    @(posedge clk);
    #1;
    zero_check("rsthold");
    rst = 1'b0;
    model_reset();
    send_rand(64, 1);
    for (int j = 0; j < 64; j++) begin
      send(16'h00FF, int'($urandom_range(1, 0)));
      if (j == 9) begin
        chk("sat8", 4, 32'(r4), 255);
        chk("sat16avg", 1, 32'(r1), 255);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample and result width in bits.
REQ-002 SHALL have parameter ROW_LEN, default 8, samples per input row; even, >=2.
REQ-003 SHALL have parameter NUM_ROWS, default 8, rows per frame; even, >=2.
REQ-004 SHALL have parameter MODE, default 0, pooling mode: 0 = max, 1 = average.
REQ-005 SHALL have parameter SIGNED, default 0, sample interpretation: 0 = unsigned, 1 = two's complement.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port load, input, 1, sample-valid qualifier; in is accepted on a rising clk edge with load=1.
REQ-009 SHALL have port in, input, DATA_W, input sample in raster order: row-major, left to right.
REQ-010 SHALL have port result, output, DATA_W, pooled value of the most recently completed 2x2 window.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse marking result and addr as new.
REQ-012 SHALL have port addr, output, AW = clog2((ROW_LEN/2)*(NUM_ROWS/2)), raster index of the output window.
REQ-013 SHALL have port done, output, 1, one-cycle pulse coincident with the final out_valid of a frame.

Function
REQ-014 SHALL perform 2x2, stride-2, non-overlapping pooling over a ROW_LEN x NUM_ROWS frame, producing (ROW_LEN/2)*(NUM_ROWS/2) outputs.
REQ-015 SHALL keep a column counter (0..ROW_LEN-1) and a row counter (0..NUM_ROWS-1), both advanced only on accepted samples; column wraps to 0 and increments row; row wraps to 0 at frame end.
REQ-016 SHALL, on an even row, combine each horizontal pair (columns 2k, 2k+1) into a partial value and store it in line-buffer entry k (ROW_LEN/2 entries, DATA_W+1 bits each).
REQ-017 SHALL, on an odd row, combine the horizontal pair at columns 2k, 2k+1 with line-buffer entry k to complete window k.
REQ-018 SHALL, in MODE 0, partial = max of the pair and result = max of partial and odd-row pair, comparing per SIGNED.
REQ-019 SHALL, in MODE 1, partial = sum of the pair (DATA_W+1 bits) and result = (sum of all four, DATA_W+2 bits) shifted right by 2; arithmetic shift (floor) when SIGNED=1, logical shift when SIGNED=0; no rounding, no overflow possible.
REQ-020 SHALL hold the first sample of a pair in a holding register until its partner is accepted.
REQ-021 SHALL assert out_valid for exactly one cycle, in the cycle after the edge that accepts column 2k+1 of an odd row (latency 1 clock).
REQ-022 SHALL hold result and addr stable between out_valid pulses.
REQ-023 SHALL tolerate any number of load=0 cycles between any two samples, including within a pair; gaps change only timing, never values.
REQ-024 SHALL start addr at 0 for the first window of each frame and increment it by 1 per window, wrapping to 0 after the last window.
REQ-025 SHALL assert done with the out_valid of window (ROW_LEN/2)*(NUM_ROWS/2)-1, then accept the next frame's samples on the following edge with no idle cycle required.
REQ-026 SHALL allow the line-buffer entry k to be read for row r+1 and rewritten for row r+2 without conflict; the entry is consumed before it is overwritten.

Reset
REQ-027 SHALL, while rst=1, drive result=0, out_valid=0, addr=0, done=0, and clear all counters and the holding register, regardless of clk.
REQ-028 SHALL, on rst asserted mid-frame, discard the partial frame; the first sample accepted after release is row 0, column 0.
REQ-029 SHALL NOT require line-buffer contents to be reset; they are always written before they are read.

Verification
REQ-030 SHALL verify MODE=0, SIGNED=0: row0 starts 38,34,25,27; row1 starts 45,12,10,6 -> addr 0 result 45, addr 1 result 27, each out_valid one clock after the 2nd and 4th row1 samples.
REQ-031 SHALL verify MODE=1 with the same data -> addr 0 result 32 (129>>2), addr 1 result 17 (68>>2).
REQ-032 SHALL verify MODE=0/1 with SIGNED=1, window -5,-3 / -8,-1 -> max result -1; average result -5 (sum -17, floor division).
REQ-033 SHALL verify a full 8x8 frame with random load gaps -> exactly 16 out_valid pulses, addr 0..15 in order, done coincident only with addr 15; a back-to-back second frame restarts at addr 0.
REQ-034 SHALL verify reset after 5 accepted samples of row 1 -> all outputs 0 immediately; a subsequent fresh frame produces addr 0 from its own rows 0-1 only.
REQ-035 SHALL verify with DATA_W=8 and all inputs 255, MODE=1 -> result 255, with no overflow.
